// File: rtl/bool_pkg.sv
// rtl/bool_pkg.sv - shared constants and truth-table helper for the boolean-expression library
package bool_pkg;

  // Operand index ordering is {A,B,C}; bit i of a table is the result for index i.
  typedef logic [2:0] minterm_t;
  typedef logic [7:0] tt3_t;

  // F = A&B | ~B&C
  localparam tt3_t BOOL1_TT = 8'b1110_0010;

  // Look up the result of a three-input table at a given minterm index.
  function automatic logic eval_tt(input tt3_t tt, input minterm_t idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/bool_1_core.sv
// rtl/bool_1_core.sv - combinational evaluation of expression 1 by table lookup
module bool_1_core
  import bool_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic C,
  output logic F
);

  minterm_t idx;

  // Form the minterm index and read the result from the shared table.
  always_comb begin
    idx = {A, B, C};
    F   = eval_tt(BOOL1_TT, idx);
  end

endmodule

// File: rtl/bool_1.sv
// rtl/bool_1.sv - expression 1 with combinational result, registered copy and true counter
module bool_1
  import bool_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             in_valid,
  output logic             F,
  output logic             F_q,
  output logic             F_valid,
  output logic [2:0]       minterm_q,
  output logic [CNT_W-1:0] true_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bool_1_core u_core (
    .A (A),
    .B (B),
    .C (C),
    .F (F)
  );

  // Capture accepted samples and count true results, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      F_q       <= 1'b0;
      minterm_q <= 3'b000;
      F_valid   <= 1'b0;
      true_cnt  <= '0;
    end else if (in_valid) begin
      F_q       <= F;
      minterm_q <= minterm_t'({A, B, C});
      F_valid   <= 1'b1;
      if (F && (true_cnt != CNT_MAX)) begin
        true_cnt <= true_cnt + CNT_ONE;
      end
    end else begin
      F_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bool_1.sv
// tb/tb_bool_1.sv - randomized self-checking bench for bool_1 against a behavioural model
module tb_bool_1;

  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             clk_on = 1'b0;
  logic             rst = 1'b1;
  logic             A = 1'b0;
  logic             B = 1'b0;
  logic             C = 1'b0;
  logic             in_valid = 1'b0;
  logic             F;
  logic             F_q;
  logic             F_valid;
  logic [2:0]       minterm_q;
  logic [CNT_W-1:0] true_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference state of the registered outputs
  bit       m_fq = 1'b0;
  bit       m_fv = 1'b0;
  int       m_mt = 0;
  int       m_cnt = 0;

  bool_1 #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .C         (C),
    .in_valid  (in_valid),
    .F         (F),
    .F_q       (F_q),
    .F_valid   (F_valid),
    .minterm_q (minterm_q),
    .true_cnt  (true_cnt)
  );

  always begin
    #5;
    if (clk_on) clk = ~clk;
  end

  // Expression 1 seen as a multiplexer: B selects A, otherwise C.
  function automatic bit ref_f(input bit a, input bit b, input bit c);
    return b ? a : c;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model advanced on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_fq = 0; m_fv = 0; m_mt = 0; m_cnt = 0;
    end else if (in_valid) begin
      m_fq = ref_f(A, B, C);
      m_mt = 4 * A + 2 * B + C;
      m_fv = 1;
      if (m_fq && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
    end else begin
      m_fv = 0;
    end
  end

  // Compare all outputs against the model midway through every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      check("F", int'(F), int'(ref_f(A, B, C)));
      check("F_q", int'(F_q), int'(m_fq));
      check("F_valid", int'(F_valid), int'(m_fv));
      check("minterm_q", int'(minterm_q), m_mt);
      check("true_cnt", int'(true_cnt), m_cnt);
    end
  end

  task automatic step(input bit r, input bit v, input int abc);
    rst = r;
    in_valid = v;
    {A, B, C} = 3'(abc);
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [7:0] tt_exp;
    tt_exp = 8'b1110_0010;

    // Idle-clock combinational sweep
    for (int i = 0; i < 8; i++) begin
      {A, B, C} = 3'(i);
      #2;
      check("sweep_F", int'(F), int'(tt_exp[i]));
    end

    clk_on = 1'b1;
    step(1, 0, 0);
    chk_on = 1'b1;

    step(0, 1, 3'b110);
    check("first_F_q", int'(F_q), 1);
    check("first_minterm", int'(minterm_q), 6);
    check("first_F_valid", int'(F_valid), 1);
    check("first_cnt", int'(true_cnt), 1);

    for (int i = 0; i < 3; i++) step(0, 0, 3'b010);
    check("idle_F_valid", int'(F_valid), 0);
    check("idle_F_q", int'(F_q), 1);
    check("idle_cnt", int'(true_cnt), 1);
    check("idle_F", int'(F), 0);

    for (int i = 0; i < 300; i++) step(0, 1, 3'b111);
    check("sat_cnt", int'(true_cnt), 255);

    step(1, 1, 3'b001);
    check("rst_F_q", int'(F_q), 0);
    check("rst_minterm", int'(minterm_q), 0);
    check("rst_F_valid", int'(F_valid), 0);
    check("rst_cnt", int'(true_cnt), 0);

    for (int i = 0; i < 8; i++) begin
      step(0, 1, i);
      check("lag_F_q", int'(F_q), int'(tt_exp[i]));
    end
    check("sweep_cnt", int'(true_cnt), 4);
    step(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), $urandom_range(0, 3) != 0, $urandom_range(0, 7));
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
